// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter
//   Two-port round-robin front end for one shared masked, pipelined AES S-box.
//   Port 0 is the key schedule, port 1 is the round-state datapath. At most one
//   byte is issued per cycle, always paired with one fresh-randomness word.
//   A valid/id/tag shift register runs alongside the S-box pipeline, so each
//   result goes back to its requester in issue order.
//
//   Build option: AES_SBOX_ARB_IDLE_CLEAR_EN
//     defined   - SboxXxDO/SboxRndxDO load zeros on every idle or flush cycle
//     undefined - SboxXxDO/SboxRndxDO hold the last issued byte/randomness
module aes_sbox_arbiter #(
    parameter int SHARES   = 2,
    parameter int SBOX_LAT = 5,
    parameter int TAG_W    = 4,
    parameter int RND_W    = 18
) (
    input  logic                  ClkxCI,
    input  logic                  RstxRI,
    input  logic                  FlushxSI,
    input  logic                  Req0ValidxSI,
    output logic                  Req0ReadyxSO,
    input  logic [8*SHARES-1:0]   Req0XxDI,
    input  logic [TAG_W-1:0]      Req0TagxDI,
    input  logic                  Req1ValidxSI,
    output logic                  Req1ReadyxSO,
    input  logic [8*SHARES-1:0]   Req1XxDI,
    input  logic [TAG_W-1:0]      Req1TagxDI,
    input  logic                  RndValidxSI,
    output logic                  RndReadyxSO,
    input  logic [RND_W-1:0]      RndxDI,
    output logic [8*SHARES-1:0]   SboxXxDO,
    output logic [RND_W-1:0]      SboxRndxDO,
    input  logic [8*SHARES-1:0]   SboxQxDI,
    output logic                  Resp0ValidxSO,
    output logic                  Resp1ValidxSO,
    output logic [8*SHARES-1:0]   RespQxDO,
    output logic [TAG_W-1:0]      RespTagxDO,
    output logic                  BusyxSO
);

    localparam int DW    = 8*SHARES;
    localparam int CNT_W = $clog2(SBOX_LAT+3);

`ifdef AES_SBOX_ARB_IDLE_CLEAR_EN
    localparam bit IDLE_CLEAR = 1'b1;
`else
    localparam bit IDLE_CLEAR = 1'b0;
`endif

    // One tracking entry per S-box pipeline slot: who asked, and under which tag.
    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
    } trkEntry_t;

    logic                 lastGntxDP;
    logic                 issue;
    logic                 gntSel;
    logic [DW-1:0]        issX;
    trkEntry_t            issEntry;
    logic                 respAny;
    logic [CNT_W-1:0]     cntxDP;

    // Valid bits and entries of the tracking pipe; index SBOX_LAT is the tail,
    // which lines up with the S-box output for the same byte.
    logic      [SBOX_LAT:0] trkVldxDP;
    trkEntry_t [SBOX_LAT:0] trkxDP;

    // Arbitration: round-robin on contention, issue only with fresh randomness.
    always_comb begin
        issue        = RndValidxSI & ~FlushxSI & ~RstxRI & (Req0ValidxSI | Req1ValidxSI);
        gntSel       = (Req0ValidxSI & Req1ValidxSI) ? ~lastGntxDP : Req1ValidxSI;
        Req0ReadyxSO = issue & ~gntSel;
        Req1ReadyxSO = issue &  gntSel;
        RndReadyxSO  = issue;
        issX         = gntSel ? Req1XxDI : Req0XxDI;
        issEntry.id  = gntSel;
        issEntry.tag = gntSel ? Req1TagxDI : Req0TagxDI;
    end

    // S-box input register and round-robin pointer; the pointer moves only on issue.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            SboxXxDO   <= '0;
            SboxRndxDO <= '0;
            lastGntxDP <= 1'b1;
        end else if (issue) begin
            SboxXxDO   <= issX;
            SboxRndxDO <= RndxDI;
            lastGntxDP <= gntSel;
        end else if (IDLE_CLEAR) begin
            SboxXxDO   <= '0;
            SboxRndxDO <= '0;
        end
    end

    // Tracking pipe: valids cleared on flush so stale S-box contents never respond.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI || FlushxSI) begin
            trkVldxDP <= '0;
        end else begin
            trkVldxDP <= {trkVldxDP[SBOX_LAT-1:0], issue};
        end
    end

    // Tracking entries follow their valids; content only matters where valid is set.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            trkxDP <= '0;
        end else begin
            trkxDP <= {trkxDP[SBOX_LAT-1:0], issEntry};
        end
    end

    // Response register: capture the S-box output when a tracked byte reaches the tail.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            Resp0ValidxSO <= 1'b0;
            Resp1ValidxSO <= 1'b0;
            RespQxDO      <= '0;
            RespTagxDO    <= '0;
        end else if (FlushxSI) begin
            Resp0ValidxSO <= 1'b0;
            Resp1ValidxSO <= 1'b0;
        end else begin
            Resp0ValidxSO <= trkVldxDP[SBOX_LAT] & ~trkxDP[SBOX_LAT].id;
            Resp1ValidxSO <= trkVldxDP[SBOX_LAT] &  trkxDP[SBOX_LAT].id;
            if (trkVldxDP[SBOX_LAT]) begin
                RespQxDO   <= SboxQxDI;
                RespTagxDO <= trkxDP[SBOX_LAT].tag;
            end
        end
    end

    assign respAny = Resp0ValidxSO | Resp1ValidxSO;

    // In-flight counter: a byte counts from the S-box input register up to and
    // including the cycle its response pulse is visible.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI || FlushxSI) begin
            cntxDP <= '0;
        end else begin
            case ({issue, respAny})
                2'b10:   cntxDP <= cntxDP + CNT_W'(1);
                2'b01:   cntxDP <= cntxDP - CNT_W'(1);
                default: cntxDP <= cntxDP;
            endcase
        end
    end

    assign BusyxSO = (cntxDP != '0);

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Directed bench for aes_sbox_arbiter with a behavioural 5-stage masked S-box.
module tb_aes_sbox_arbiter;
    localparam int SHARES = 2, SBOX_LAT = 5, TAG_W = 4, RND_W = 18, L = SBOX_LAT + 2;

`ifdef AES_SBOX_ARB_IDLE_CLEAR_EN
    localparam bit IDLE_CLR = 1'b1;
`else
    localparam bit IDLE_CLR = 1'b0;
`endif

    logic ClkxCI = 1'b0, RstxRI, FlushxSI;
    logic Req0ValidxSI, Req0ReadyxSO, Req1ValidxSI, Req1ReadyxSO;
    logic [15:0] Req0XxDI, Req1XxDI, SboxXxDO, SboxQxDI, RespQxDO;
    logic [3:0]  Req0TagxDI, Req1TagxDI, RespTagxDO;
    logic RndValidxSI, RndReadyxSO;
    logic [17:0] RndxDI, SboxRndxDO;
    logic Resp0ValidxSO, Resp1ValidxSO, BusyxSO;

    int checks = 0, errors = 0, cyc = 0, t0;

    aes_sbox_arbiter #(.SHARES(SHARES), .SBOX_LAT(SBOX_LAT), .TAG_W(TAG_W), .RND_W(RND_W)) dut (
        .ClkxCI(ClkxCI), .RstxRI(RstxRI), .FlushxSI(FlushxSI),
        .Req0ValidxSI(Req0ValidxSI), .Req0ReadyxSO(Req0ReadyxSO), .Req0XxDI(Req0XxDI), .Req0TagxDI(Req0TagxDI),
        .Req1ValidxSI(Req1ValidxSI), .Req1ReadyxSO(Req1ReadyxSO), .Req1XxDI(Req1XxDI), .Req1TagxDI(Req1TagxDI),
        .RndValidxSI(RndValidxSI), .RndReadyxSO(RndReadyxSO), .RndxDI(RndxDI),
        .SboxXxDO(SboxXxDO), .SboxRndxDO(SboxRndxDO), .SboxQxDI(SboxQxDI),
        .Resp0ValidxSO(Resp0ValidxSO), .Resp1ValidxSO(Resp1ValidxSO),
        .RespQxDO(RespQxDO), .RespTagxDO(RespTagxDO), .BusyxSO(BusyxSO));

    always #5 ClkxCI = ~ClkxCI;
    always @(posedge ClkxCI) cyc <= cyc + 1;

    // AES S-box reference: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = '0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Masked output: shares re-randomised, but their XOR is sbox(x0 ^ x1).
    function automatic logic [15:0] maskedSbox(input logic [15:0] xs, input logic [17:0] r);
        logic [7:0] m;
        m = xs[15:8] ^ r[7:0];
        return {m, sbox(xs[7:0] ^ xs[15:8]) ^ m};
    endfunction

    logic [15:0] sbPipe [SBOX_LAT] = '{default: '0};
    always @(posedge ClkxCI) begin
        sbPipe[0] <= maskedSbox(SboxXxDO, SboxRndxDO);
        for (int k = 1; k < SBOX_LAT; k++) sbPipe[k] <= sbPipe[k-1];
    end
    assign SboxQxDI = sbPipe[SBOX_LAT-1];

    typedef struct { int id; logic [3:0] tag; logic [7:0] val; int c; } rsp_t;
    rsp_t got[$], exq[$];

    // Response monitor: id 2 flags both valids high at once.
    always @(negedge ClkxCI) begin
        rsp_t r;
        if (Resp0ValidxSO | Resp1ValidxSO) begin
            r.id  = (Resp0ValidxSO & Resp1ValidxSO) ? 2 : (Resp1ValidxSO ? 1 : 0);
            r.tag = RespTagxDO;
            r.val = RespQxDO[7:0] ^ RespQxDO[15:8];
            r.c   = cyc;
            got.push_back(r);
        end
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
        end
    endtask

    task automatic expect_rsp(input int id, input logic [3:0] tag, input logic [7:0] val, input int c);
        rsp_t e;
        e.id = id; e.tag = tag; e.val = val; e.c = c;
        exq.push_back(e);
    endtask

    task automatic checkResp(input string nm);
        chk({nm, "_count"}, got.size(), exq.size());
        for (int i = 0; i < exq.size() && i < got.size(); i++) begin
            chk({nm, "_id"},  got[i].id,  exq[i].id);
            chk({nm, "_tag"}, got[i].tag, exq[i].tag);
            chk({nm, "_val"}, got[i].val, exq[i].val);
            chk({nm, "_cyc"}, got[i].c,   exq[i].c);
        end
        got.delete();
        exq.delete();
    endtask

    task automatic tick();
        @(posedge ClkxCI);
        #1;
    endtask

    task automatic idleIn();
        Req0ValidxSI = 0; Req1ValidxSI = 0; RndValidxSI = 0; FlushxSI = 0;
    endtask

    task automatic chkAllZero(input string nm);
        chk({nm, "_sboxx"}, SboxXxDO, 0);
        chk({nm, "_sboxrnd"}, SboxRndxDO, 0);
        chk({nm, "_respq"}, RespQxDO, 0);
        chk({nm, "_resptag"}, RespTagxDO, 0);
        chk({nm, "_resp0"}, Resp0ValidxSO, 0);
        chk({nm, "_resp1"}, Resp1ValidxSO, 0);
        chk({nm, "_busy"}, BusyxSO, 0);
    endtask

    initial begin
        RstxRI = 1; idleIn();
        Req0XxDI = '0; Req1XxDI = '0; Req0TagxDI = '0; Req1TagxDI = '0; RndxDI = '0;
        tick(); tick();
        // Requests during reset must not be accepted
        Req0ValidxSI = 1; RndValidxSI = 1; #1;
        chk("rst_rdy0", Req0ReadyxSO, 0);
        chk("rst_rndrdy", RndReadyxSO, 0);
        tick();
        chkAllZero("rst");
        RstxRI = 0; idleIn(); tick();
        got.delete();

        // T1 single request, plus idle behaviour of SboxXxDO (T6)
        Req0ValidxSI = 1; Req0XxDI = 16'h0053; Req0TagxDI = 4'd3; RndValidxSI = 1; RndxDI = 18'h2A5A5; #1;
        chk("t1_rdy0", Req0ReadyxSO, 1);
        chk("t1_rdy1", Req1ReadyxSO, 0);
        chk("t1_rndrdy", RndReadyxSO, 1);
        chk("t1_busy0", BusyxSO, 0);
        t0 = cyc;
        expect_rsp(0, 4'd3, 8'hED, t0 + L);
        tick(); idleIn();
        chk("t1_sboxx", SboxXxDO, 16'h0053);
        chk("t1_sboxrnd", SboxRndxDO, 18'h2A5A5);
        for (int k = 1; k <= L; k++) begin
            chk("t1_busy", BusyxSO, 1);
            chk("t1_resp0", Resp0ValidxSO, (k == L));
            if (k == 2) chk("t6_sboxx_idle", SboxXxDO, IDLE_CLR ? 16'h0000 : 16'h0053);
            if (k == L) begin
                chk("t1_tag", RespTagxDO, 4'd3);
                chk("t1_q", RespQxDO[7:0] ^ RespQxDO[15:8], 8'hED);
            end
            tick();
        end
        chk("t1_busy_end", BusyxSO, 0);
        chk("t1_resp0_end", Resp0ValidxSO, 0);
        checkResp("t1");

        // T3 randomness starvation
        Req1ValidxSI = 1; Req1XxDI = 16'h7711; Req1TagxDI = 4'd5; RndValidxSI = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_rdy1_starve", Req1ReadyxSO, 0);
            chk("t3_rndrdy_starve", RndReadyxSO, 0);
            chk("t3_busy_starve", BusyxSO, 0);
            tick();
        end
        RndValidxSI = 1; RndxDI = 18'h3C3C3; #1;
        chk("t3_rdy1", Req1ReadyxSO, 1);
        chk("t3_rndrdy", RndReadyxSO, 1);
        chk("t3_rdy0", Req0ReadyxSO, 0);
        expect_rsp(1, 4'd5, sbox(8'h66), cyc + L);
        tick(); idleIn();
        repeat (L + 1) tick();
        checkResp("t3");

        // T4 flush after four back-to-back bytes
        for (int i = 0; i < 4; i++) begin
            Req0ValidxSI = 1; Req0XxDI = {8'hA0 + 8'(i), 8'h0F}; Req0TagxDI = 4'(i);
            RndValidxSI = 1; RndxDI = 18'(i * 311); #1;
            chk("t4_rdy0", Req0ReadyxSO, 1);
            tick();
        end
        FlushxSI = 1; Req0XxDI = 16'h1234; Req0TagxDI = 4'd9; #1;
        chk("t4_flush_rdy0", Req0ReadyxSO, 0);
        chk("t4_flush_rndrdy", RndReadyxSO, 0);
        tick();
        FlushxSI = 0;
        chk("t4_busy_after_flush", BusyxSO, 0);
        chk("t4_sboxx_after_flush", SboxXxDO, IDLE_CLR ? 16'h0000 : 16'hA30F);
        #1;
        chk("t4_rdy0_tag9", Req0ReadyxSO, 1);
        expect_rsp(0, 4'd9, sbox(8'h26), cyc + L);
        tick(); idleIn();
        repeat (L + 1) tick();
        checkResp("t4");

        // T5 reset with three bytes in flight
        for (int i = 0; i < 3; i++) begin
            Req0ValidxSI = 1; Req0XxDI = {8'h11 * 8'(i + 1), 8'h22}; Req0TagxDI = 4'(12 + i);
            RndValidxSI = 1; RndxDI = 18'h15555; #1;
            chk("t5_rdy0", Req0ReadyxSO, 1);
            tick();
        end
        RstxRI = 1; #1;
        chk("t5_rst_rdy0", Req0ReadyxSO, 0);
        tick(); idleIn();
        chkAllZero("t5");
        RstxRI = 0;

        // T2 contention right after reset: grants 0,1,0,1,...
        for (int i = 0; i < 8; i++) begin
            int g;
            Req0ValidxSI = 1; Req1ValidxSI = 1; RndValidxSI = 1;
            Req0XxDI = {8'h5A, 8'(i)};        Req0TagxDI = 4'(i);
            Req1XxDI = {8'hC3, 8'h40 + 8'(i)}; Req1TagxDI = 4'(i) | 4'd8;
            RndxDI = 18'(i * 77); #1;
            g = i % 2;
            chk("t2_rdy0", Req0ReadyxSO, (g == 0));
            chk("t2_rdy1", Req1ReadyxSO, (g == 1));
            chk("t2_rndrdy", RndReadyxSO, 1);
            if (g == 0) expect_rsp(0, 4'(i), sbox(8'h5A ^ 8'(i)), cyc + L);
            else        expect_rsp(1, 4'(i) | 4'd8, sbox(8'hC3 ^ (8'h40 + 8'(i))), cyc + L);
            tick();
        end
        idleIn();
        repeat (L + 2) tick();
        chk("t2_busy_end", BusyxSO, 0);
        checkResp("t2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
